// File: rtl/donut_pkg.sv
// Shared fixed-point constants, saturation helpers and marcher FSM states for the donut renderer.
package donut_pkg;
  localparam int FRAC   = 10;
  localparam int IN_W   = 16;
  localparam int DATA_W = 18;
  localparam int WIDE_W = 40;
  localparam int ITERS  = 6;
  localparam int LSH    = 5;

  localparam logic signed [DATA_W-1:0] R_RING  = 18'sd1024;
  localparam logic signed [DATA_W-1:0] R_TUBE  = 18'sd512;
  localparam logic signed [DATA_W-1:0] HIT_EPS = 18'sd16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XZ,
    ST_TOR,
    ST_SXZ,
    ST_STOR
  } state_t;

  // Symmetric clamp: the most negative code is never produced.
  function automatic logic signed [DATA_W-1:0] sat18(input logic signed [WIDE_W-1:0] x);
    if (x > 40'sd131071) return 18'sd131071;
    if (x < -40'sd131071) return -18'sd131071;
    return x[DATA_W-1:0];
  endfunction

  function automatic logic signed [IN_W-1:0] sat16(input logic signed [WIDE_W-1:0] x);
    if (x > 40'sd32767) return 16'sd32767;
    if (x < -40'sd32767) return -16'sd32767;
    return x[IN_W-1:0];
  endfunction
endpackage

// File: rtl/donut_len2.sv
// Alpha-max-beta-min magnitude of a 2-D vector: max + min/4 + min/8, saturated.
module donut_len2
  import donut_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_mag
);
  logic signed [DATA_W:0] w_abs_a;
  logic signed [DATA_W:0] w_abs_b;
  logic signed [DATA_W:0] w_max;
  logic signed [DATA_W:0] w_min;

  assign w_abs_a = i_a[DATA_W-1] ? -(DATA_W+1)'(i_a) : (DATA_W+1)'(i_a);
  assign w_abs_b = i_b[DATA_W-1] ? -(DATA_W+1)'(i_b) : (DATA_W+1)'(i_b);
  assign w_max   = (w_abs_a > w_abs_b) ? w_abs_a : w_abs_b;
  assign w_min   = (w_abs_a > w_abs_b) ? w_abs_b : w_abs_a;
  assign o_mag   = sat18(WIDE_W'(w_max) + WIDE_W'(w_min >>> 2) + WIDE_W'(w_min >>> 3));
endmodule

// File: rtl/donut_sdf_marcher.sv
// Per-pixel torus sphere-tracer: fixed 15-cycle query returning hit and a gradient-dot-light shade.
module donut_sdf_marcher
  import donut_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic signed [IN_W-1:0] pxin,
  input  logic signed [IN_W-1:0] pyin,
  input  logic signed [IN_W-1:0] pzin,
  input  logic signed [IN_W-1:0] rxin,
  input  logic signed [IN_W-1:0] ryin,
  input  logic signed [IN_W-1:0] rzin,
  input  logic signed [IN_W-1:0] lxin,
  input  logic signed [IN_W-1:0] lyin,
  input  logic signed [IN_W-1:0] lzin,
  output logic                   busy,
  output logic                   done,
  output logic                   hit,
  output logic signed [IN_W-1:0] light
);
  state_t r_state;
  state_t w_next;
  logic [2:0] r_cnt;
  logic r_hitflag;
  logic r_done;
  logic r_hit;
  logic signed [IN_W-1:0] r_light;

  logic signed [DATA_W-1:0] r_px, r_py, r_pz, r_t, r_d;
  logic signed [IN_W-1:0] r_rx, r_ry, r_rz, r_lx, r_ly, r_lz;

  logic signed [DATA_W-1:0] w_qx, w_qy, w_qz, w_tr;
  logic signed [DATA_W-1:0] w_la, w_lb, w_mag, w_dist;
  logic signed [DATA_W-1:0] w_stepx, w_stepy, w_stepz;
  logic signed [DATA_W-1:0] w_diff;
  logic signed [IN_W-1:0] w_shade;
  logic w_near, w_last, w_hit_res;

  // Shading probe point p - eps*l, evaluated by the same two-stage SDF hardware.
  assign w_qx = sat18(WIDE_W'(r_px) - WIDE_W'(r_lx >>> LSH));
  assign w_qy = sat18(WIDE_W'(r_py) - WIDE_W'(r_ly >>> LSH));
  assign w_qz = sat18(WIDE_W'(r_pz) - WIDE_W'(r_lz >>> LSH));
  assign w_tr = sat18(WIDE_W'(r_t) - WIDE_W'(R_RING));

  always_comb begin
    w_la = r_px;
    w_lb = r_pz;
    case (r_state)
      ST_SXZ:  begin w_la = w_qx; w_lb = w_qz; end
      ST_TOR:  begin w_la = w_tr; w_lb = r_py; end
      ST_STOR: begin w_la = w_tr; w_lb = w_qy; end
      default: ;
    endcase
  end

  donut_len2 u_len2 (
    .i_a   (w_la),
    .i_b   (w_lb),
    .o_mag (w_mag)
  );

  assign w_dist    = sat18(WIDE_W'(w_mag) - WIDE_W'(R_TUBE));
  assign w_near    = (w_dist < HIT_EPS);
  assign w_last    = (r_cnt == 3'(ITERS - 1));
  assign w_stepx   = sat18(WIDE_W'((34'(r_rx) * 34'(w_dist)) >>> FRAC));
  assign w_stepy   = sat18(WIDE_W'((34'(r_ry) * 34'(w_dist)) >>> FRAC));
  assign w_stepz   = sat18(WIDE_W'((34'(r_rz) * 34'(w_dist)) >>> FRAC));
  assign w_hit_res = r_hitflag | (r_d < HIT_EPS);
  assign w_diff    = sat18(WIDE_W'(r_d) - WIDE_W'(w_dist));
  assign w_shade   = sat16(WIDE_W'(w_diff) <<< LSH);

  // A start strobe always wins: it abandons any query in flight.
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = ST_XZ;
    end else begin
      case (r_state)
        ST_XZ:   w_next = ST_TOR;
        ST_TOR:  w_next = w_last ? ST_SXZ : ST_XZ;
        ST_SXZ:  w_next = ST_STOR;
        ST_STOR: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_hitflag <= 1'b0;
      r_done    <= 1'b0;
      r_hit     <= 1'b0;
      r_light   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (start) begin
        r_cnt     <= 3'd0;
        r_hitflag <= 1'b0;
      end else begin
        case (r_state)
          ST_TOR: begin
            r_cnt <= r_cnt + 3'd1;
            if (w_near) r_hitflag <= 1'b1;
          end
          ST_STOR: begin
            r_done  <= 1'b1;
            r_hit   <= w_hit_res;
            r_light <= w_hit_res ? w_shade : '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Once a hit is seen p stays frozen; the remaining steps recompute the same distance.
  always_ff @(posedge clk) begin
    if (start) begin
      r_px <= DATA_W'(pxin);
      r_py <= DATA_W'(pyin);
      r_pz <= DATA_W'(pzin);
      r_rx <= rxin;
      r_ry <= ryin;
      r_rz <= rzin;
      r_lx <= lxin;
      r_ly <= lyin;
      r_lz <= lzin;
    end else begin
      case (r_state)
        ST_XZ, ST_SXZ: r_t <= w_mag;
        ST_TOR: begin
          r_d <= w_dist;
          if (!r_hitflag && !w_near) begin
            r_px <= sat18(WIDE_W'(r_px) + WIDE_W'(w_stepx));
            r_py <= sat18(WIDE_W'(r_py) + WIDE_W'(w_stepy));
            r_pz <= sat18(WIDE_W'(r_pz) + WIDE_W'(w_stepz));
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != ST_IDLE) | r_done;
  assign done  = r_done;
  assign hit   = r_hit;
  assign light = r_light;
endmodule

// File: tb/tb_donut_sdf_marcher.sv
// Directed-vector and sequence bench for the torus SDF marcher, plus model-checked random rays.
module tb_donut_sdf_marcher;
  typedef struct {
    string name;
    int px, py, pz, rx, ry, rz, lx, ly, lz;
    int exp_hit;
    int exp_light;
    int tol;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [15:0] pxin, pyin, pzin, rxin, ryin, rzin, lxin, lyin, lzin;
  logic busy, done, hit;
  logic signed [15:0] light;

  int total = 0;
  int bad = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  donut_sdf_marcher dut (
    .clk(clk), .rst(rst), .start(start),
    .pxin(pxin), .pyin(pyin), .pzin(pzin),
    .rxin(rxin), .ryin(ryin), .rzin(rzin),
    .lxin(lxin), .lyin(lyin), .lzin(lzin),
    .busy(busy), .done(done), .hit(hit), .light(light)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int got, input int exp, input int tol);
    total++;
    if (got < exp - tol || got > exp + tol) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d+/-%0d", nm, got, exp, tol);
    end
  endtask

  task automatic drive(input vec_t v);
    pxin = 16'(v.px); pyin = 16'(v.py); pzin = 16'(v.pz);
    rxin = 16'(v.rx); ryin = 16'(v.ry); rzin = 16'(v.rz);
    lxin = 16'(v.lx); lyin = 16'(v.ly); lzin = 16'(v.lz);
  endtask

  // Called in cycle 1 of a query; returns the cycle index at which done is seen (-1 on timeout).
  task automatic wait_done(input string nm, output int lat);
    int busy_ok;
    busy_ok = 1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
    chk({nm, "_busy"}, busy_ok, 1);
  endtask

  task automatic run_query(input vec_t v, output int h, output int lt, output int lat);
    drive(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(v.name, lat);
    h = int'(hit);
    lt = int'(light);
  endtask

  function automatic longint s18(input longint x);
    if (x > 131071) return 131071;
    if (x < -131071) return -131071;
    return x;
  endfunction

  function automatic longint s16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32767) return -32767;
    return x;
  endfunction

  function automatic longint l2(input longint a, input longint b);
    longint aa, bb, mx, mn;
    aa = (a < 0) ? -a : a;
    bb = (b < 0) ? -b : b;
    mx = (aa > bb) ? aa : bb;
    mn = (aa > bb) ? bb : aa;
    return s18(mx + (mn >>> 2) + (mn >>> 3));
  endfunction

  function automatic longint sdf(input longint x, input longint y, input longint z);
    return s18(l2(s18(l2(x, z) - 1024), y) - 512);
  endfunction

  task automatic model(input vec_t v, output int h, output int lt);
    longint p[3], r[3], l[3], q[3];
    longint d, d1;
    int hf;
    p[0] = v.px; p[1] = v.py; p[2] = v.pz;
    r[0] = v.rx; r[1] = v.ry; r[2] = v.rz;
    l[0] = v.lx; l[1] = v.ly; l[2] = v.lz;
    hf = 0;
    d = 0;
    for (int it = 0; it < 6; it++) begin
      d = sdf(p[0], p[1], p[2]);
      if (d < 16) hf = 1;
      else if (hf == 0)
        for (int k = 0; k < 3; k++) p[k] = s18(p[k] + s18((r[k] * d) >>> 10));
    end
    for (int k = 0; k < 3; k++) q[k] = s18(p[k] - (l[k] >>> 5));
    d1 = sdf(q[0], q[1], q[2]);
    h = (hf != 0 || d < 16) ? 1 : 0;
    lt = (h != 0) ? int'(s16(s18(d - d1) * 32)) : 0;
  endtask

  initial begin
    int h, lt, lat, ndone, stable, prev_h, prev_l, mh, ml;
    vec_t rv;

    vecs[0] = '{"s1_hit",    0, 0, -3072,    0, 0, 1024,    0, 0,    0, 1,     0,  0};
    vecs[1] = '{"s2_hole",   0, -3072, 0,    0, 1024, 0,    0, 0,    0, 0,     0,  0};
    vecs[2] = '{"s3_lneg",   0, 0, -3072,    0, 0, 1024,    0, 0, -256, 1,   256, 16};
    vecs[3] = '{"s3_lpos",   0, 0, -3072,    0, 0, 1024,    0, 0,  256, 1,  -256, 16};
    vecs[4] = '{"ring_ctr",  1024, 0, 0,  1024, 0, 0,    1024, 0,    0, 1, -1024,  0};
    vecs[5] = '{"miss_away", 4096, 0, 0,  1024, 0, 0,       0, 0,  256, 0,     0,  0};
    vecs[6] = '{"s2_lnz",    0, -3072, 0,    0, 1024, 0,    0, 0,  256, 0,     0,  0};

    rst = 1'b0;
    start = 1'b0;
    drive(vecs[0]);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_light", int'(light), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_query(vecs[i], h, lt, lat);
      chk({vecs[i].name, "_lat"}, lat, 15);
      chk({vecs[i].name, "_hit"}, h, vecs[i].exp_hit);
      chk_tol({vecs[i].name, "_light"}, lt, vecs[i].exp_light, vecs[i].tol);
      tick();
    end
    chk("idle_busy", int'(busy), 0);

    // Restart at cycle 5 with the through-the-hole ray: only the second query completes.
    drive(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    drive(vecs[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("abandon", lat);
    chk("abandon_lat", lat, 15);
    chk("abandon_hit", int'(hit), 0);
    tick();

    // New start in the very cycle done is high.
    run_query(vecs[4], h, lt, lat);
    chk("b2b_a_lat", lat, 15);
    chk("b2b_a_light", lt, -1024);
    drive(vecs[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_hold_hit", int'(hit), 1);
    wait_done("b2b_b", lat);
    chk("b2b_b_lat", lat, 15);
    chk("b2b_b_hit", int'(hit), 0);
    tick();

    // Asynchronous reset in cycle 7 of a query.
    run_query(vecs[3], h, lt, lat);
    chk("pre_rst_light", lt, -256);
    tick();
    drive(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_hit", int'(hit), 0);
    chk("arst_light", int'(light), 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("arst_no_done", ndone, 0);

    // Random rays at a strict 16-cycle start cadence.
    prev_h = 0;
    prev_l = 0;
    for (int q = 0; q < 8; q++) begin
      rv.name = "rnd";
      if (q % 2 == 0) begin
        rv.px = int'($urandom_range(6000, 0)) - 3000;
        rv.py = int'($urandom_range(6000, 0)) - 3000;
        rv.pz = int'($urandom_range(6000, 0)) - 3000;
        rv.rx = int'($urandom_range(2048, 0)) - 1024;
        rv.ry = int'($urandom_range(2048, 0)) - 1024;
        rv.rz = int'($urandom_range(2048, 0)) - 1024;
      end else begin
        rv.px = 1024 + int'($urandom_range(600, 0)) - 300;
        rv.py = int'($urandom_range(600, 0)) - 300;
        rv.pz = -3072;
        rv.rx = int'($urandom_range(200, 0)) - 100;
        rv.ry = int'($urandom_range(200, 0)) - 100;
        rv.rz = 1024;
      end
      rv.lx = int'($urandom_range(1024, 0)) - 512;
      rv.ly = int'($urandom_range(1024, 0)) - 512;
      rv.lz = int'($urandom_range(1024, 0)) - 512;
      rv.exp_hit = 0;
      rv.exp_light = 0;
      rv.tol = 0;
      model(rv, mh, ml);
      drive(rv);
      start = 1'b1;
      tick();
      start = 1'b0;
      stable = 1;
      for (int c = 1; c <= 15; c++) begin
        if (c < 15) begin
          if (done !== 1'b0 || int'(hit) != prev_h || int'(light) != prev_l) stable = 0;
          tick();
        end
      end
      chk("rnd_stable", stable, 1);
      chk("rnd_done", int'(done), 1);
      chk("rnd_hit", int'(hit), mh);
      chk("rnd_light", int'(light), ml);
      prev_h = mh;
      prev_l = ml;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
